mem_rr_scheduler: RTL and testbench
===================================

Name: mem_rr_scheduler

Overview:
Round-robin transaction scheduler that shares the single block-wide memory port between NUM_REQ cache-side requesters (icache, dcache, uncached/DMA path).
- Accepts one request at a time and latches its address, write data and byte strobes.
- Holds the memory request stable until mem_ready_i, then returns a registered response to the granted requester only.
- A watchdog counter terminates hung transactions with an error response.

Parameters:
NUM_REQ, 3, number of requesters; index 0 = icache, 1 = dcache, 2 = uncached/DMA
ADDR_W, 32, address width
DATA_W, 128, block width (BLK_SIZE)
STRB_W, DATA_W/8, byte-strobe width (derived)
TIMEOUT, 255, max cycles in BUSY before forced error completion; must be >= 1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W]
req_wdata_i  in  NUM_REQ*DATA_W  packed write data
req_wstrb_i  in  NUM_REQ*STRB_W  packed byte strobes; all-zero = read
req_ready_o  out  NUM_REQ  one-hot one-cycle accept pulse
res_valid_o  out  NUM_REQ  one-hot one-cycle response pulse
res_data_o  out  DATA_W  response data, shared by all requesters; valid with res_valid_o
res_err_o  out  1  response terminated by timeout; valid with res_valid_o
mem_valid_o  out  1  memory request valid
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_wstrb_o  out  STRB_W  memory byte strobes
mem_ready_i  in  1  memory completion; rdata valid same cycle
mem_rdata_i  in  DATA_W  memory read data
grant_o  out  NUM_REQ  one-hot owner of the current transaction; 0 in IDLE
busy_o  out  1  state != IDLE

Behaviour:
Reset values:
- state = IDLE; rr_ptr = NUM_REQ-1, so requester 0 has first priority after reset.
- Every output is 0.

FSM states: IDLE, BUSY, RESP.

IDLE:
- If any req_valid_i is set, pick the first set bit searching (rr_ptr+1) mod NUM_REQ upward with wrap.
- Same cycle: req_ready_o[g]=1 (combinational from state and req_valid_i).
- Latch addr, wdata and wstrb of g; set grant; rr_ptr <= g; clear the timeout counter; next state BUSY.
- If no req_valid_i is set, stay in IDLE.

BUSY:
- mem_valid_o=1; mem_addr_o, mem_wdata_o and mem_wstrb_o driven from the latched registers, stable for the whole state.
- req_valid_i changes are ignored. No new accepts (req_ready_o=0).
- If mem_ready_i: latch mem_rdata_i into the response register, err=0, go to RESP.
- Else if counter == TIMEOUT-1: response data=0, err=1, go to RESP.
- Else increment counter (width clog2(TIMEOUT+1), saturating).
- mem_ready_i and timeout in the same cycle: mem_ready_i wins, err=0.

RESP:
- res_valid_o[grant]=1 for exactly one cycle; res_data_o and res_err_o come from registers.
- For writes, res_data_o = captured mem_rdata_i (don't-care to requester).
- Next state IDLE. grant_o clears on entry to IDLE.

Timing and latency:
- Accept at cycle t; mem_valid_o rises at t+1.
- mem_ready_i at cycle m gives res_valid_o at m+1.
- Next accept possible at m+2, so there is one dead cycle per transaction.
- mem_valid_o is registered, never combinational from req_valid_i.

Requester and memory-side rules:
- A requester holds req_valid_i and its payload until it sees req_ready_o. It may re-assert a new request immediately after.
- mem_ready_i outside BUSY is ignored.
- mem_wstrb_o is passed through unmodified; the requester computes strobes.

Fairness:
- rr_ptr updates only on accept.
- With all requesters continuously valid, grants rotate 0,1,2,0,...
- No requester waits more than NUM_REQ-1 transactions.

Reset mid-operation:
- Any state returns to IDLE next cycle and the transaction is dropped; no res_valid_o is issued.
- mem_valid_o drops the cycle after rst_i is sampled.

Test Plan:
- Reset, then req_valid_i=3'b001, addr=0x1000, wstrb=0 → req_ready_o=001 same cycle; mem_valid_o=1, mem_addr_o=0x1000 next cycle; mem_ready_i after 3 cycles with rdata=0xDEAD... → res_valid_o=001 next cycle, res_data_o=0xDEAD..., res_err_o=0.
- All three requesters valid continuously, memory ready after 1 cycle → accept order 0,1,2,0,1,2; each accept spaced 4 cycles apart; grant_o one-hot throughout.
- Requester 1 write, wstrb=0x000F, wdata=0x11223344 → mem_wstrb_o=0x000F and mem_wdata_o stable until mem_ready_i; req_valid_i[0] toggling during BUSY causes no accept.
- TIMEOUT=4, mem_ready_i never asserted → res_valid_o and res_err_o=1 exactly 5 cycles after accept (4 BUSY + 1); res_data_o=0; next request then serviced normally.
- mem_ready_i asserted on the same cycle the counter hits TIMEOUT-1 → res_err_o=0, data = mem_rdata_i.
- rst_i pulsed in BUSY → mem_valid_o=0 next cycle; no res_valid_o; rr_ptr reset so requester 0 wins a subsequent 3-way contention.

Source files
------------

// File: rtl/mem_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : mem_rr_scheduler
//  Purpose  : Round-robin arbiter sharing one memory port between NUM_REQ
//             requesters, with a watchdog that ends hung transactions in error.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_rr_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,

    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
    input  logic [NUM_REQ*STRB_W-1:0]   req_wstrb_i,
    output logic [NUM_REQ-1:0]          req_ready_o,

    output logic [NUM_REQ-1:0]          res_valid_o,
    output logic [DATA_W-1:0]           res_data_o,
    output logic                        res_err_o,

    output logic                        mem_valid_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    output logic [STRB_W-1:0]           mem_wstrb_o,
    input  logic                        mem_ready_i,
    input  logic [DATA_W-1:0]           mem_rdata_i,

    output logic [NUM_REQ-1:0]          grant_o,
    output logic                        busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0] C_LAST_REQ = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]    wstrb_q, wstrb_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic                 w_any;
    logic [PTR_W-1:0]     w_pick;
    logic [PTR_W-1:0]     w_cand;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic [STRB_W-1:0]    w_sel_wstrb;

    // Search starts one past the last winner and wraps, giving rotating priority.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_cand = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = PTR_W'((int'(rr_ptr_q) + off) % NUM_REQ);
            if (!w_any && req_valid_i[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    assign w_pick_oh   = NUM_REQ'(1) << w_pick;
    assign w_sel_addr  = req_addr_i[w_pick*ADDR_W +: ADDR_W];
    assign w_sel_wdata = req_wdata_i[w_pick*DATA_W +: DATA_W];
    assign w_sel_wstrb = req_wstrb_i[w_pick*STRB_W +: STRB_W];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    state_d  = ST_BUSY;
                    rr_ptr_d = w_pick;
                    grant_d  = w_pick_oh;
                    addr_d   = w_sel_addr;
                    wdata_d  = w_sel_wdata;
                    wstrb_d  = w_sel_wstrb;
                    cnt_d    = '0;
                end
            end
            ST_BUSY: begin
                // A real completion takes precedence over an expiring watchdog.
                if (mem_ready_i) begin
                    state_d = ST_RESP;
                    rdata_d = mem_rdata_i;
                    err_d   = 1'b0;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else if (cnt_q != C_CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= C_LAST_REQ;
            grant_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE && w_any) ? w_pick_oh : '0;

    assign mem_valid_o = (state_q == ST_BUSY);
    assign mem_addr_o  = mem_valid_o ? addr_q  : '0;
    assign mem_wdata_o = mem_valid_o ? wdata_q : '0;
    assign mem_wstrb_o = mem_valid_o ? wstrb_q : '0;

    assign res_valid_o = (state_q == ST_RESP) ? grant_q : '0;
    assign res_data_o  = (state_q == ST_RESP) ? rdata_q : '0;
    assign res_err_o   = (state_q == ST_RESP) ? err_q   : 1'b0;

    assign grant_o = grant_q;
    assign busy_o  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_rr_scheduler
//  Purpose  : Self-checking bench for mem_rr_scheduler against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_rr_scheduler;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [NR-1:0]      req_valid_i;
    logic [NR*AW-1:0]   req_addr_i;
    logic [NR*DW-1:0]   req_wdata_i;
    logic [NR*SW-1:0]   req_wstrb_i;
    logic [NR-1:0]      req_ready_o;
    logic [NR-1:0]      res_valid_o;
    logic [DW-1:0]      res_data_o;
    logic               res_err_o;
    logic               mem_valid_o;
    logic [AW-1:0]      mem_addr_o;
    logic [DW-1:0]      mem_wdata_o;
    logic [SW-1:0]      mem_wstrb_o;
    logic               mem_ready_i;
    logic [DW-1:0]      mem_rdata_i;
    logic [NR-1:0]      grant_o;
    logic               busy_o;

    mem_rr_scheduler #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .req_ready_o (req_ready_o),
        .res_valid_o (res_valid_o),
        .res_data_o  (res_data_o),
        .res_err_o   (res_err_o),
        .mem_valid_o (mem_valid_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: last winner and per-requester payloads.
    int             m_last;
    logic [AW-1:0]  m_addr  [NR];
    logic [DW-1:0]  m_wdata [NR];
    logic [SW-1:0]  m_wstrb [NR];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic new_payloads();
        for (int k = 0; k < NR; k++) begin
            m_addr[k]  = $urandom;
            m_wdata[k] = rand128();
            m_wstrb[k] = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
        end
    endtask

    task automatic drive_payloads();
        for (int k = 0; k < NR; k++) begin
            req_addr_i[k*AW +: AW]  = m_addr[k];
            req_wdata_i[k*DW +: DW] = m_wdata[k];
            req_wstrb_i[k*SW +: SW] = m_wstrb[k];
        end
    endtask

    // One transaction: mem_ready on BUSY cycle 'delay' (1-based); a delay
    // beyond TO means the memory never answers in time.
    task automatic run_txn(input logic [NR-1:0] mask, input int delay,
                           input logic [DW-1:0] rd, input bit rst_mid);
        int            w;
        int            nbusy;
        bit            timed_out;
        logic [NR-1:0] oh;
        logic [DW-1:0] exp_data;

        w = -1;
        for (int off = 1; off <= NR; off++) begin
            if (w < 0 && mask[(m_last + off) % NR]) w = (m_last + off) % NR;
        end
        oh        = 3'b001 << w;
        timed_out = (delay > TO);
        nbusy     = timed_out ? TO : delay;
        exp_data  = '0;

        @(negedge clk_i);
        req_valid_i = mask;
        mem_ready_i = 1'b0;
        drive_payloads();
        #1;
        check("accept_ready", req_ready_o, oh);
        check("idle_busy", busy_o, 0);
        check("idle_grant", grant_o, 0);
        m_last = w;

        for (int i = 1; i <= nbusy; i++) begin
            @(negedge clk_i);
            req_valid_i = NR'($urandom_range(0, 7));
            mem_ready_i = (i == delay);
            mem_rdata_i = (i == delay) ? rd : rand128();
            if (i == delay) exp_data = rd;
            if (rst_mid && i == 2) rst_i = 1'b1;
            #1;
            check("busy_ready", req_ready_o, 0);
            check("busy_mvalid", mem_valid_o, 1);
            check("busy_addr", mem_addr_o, m_addr[w]);
            check("busy_wdata", mem_wdata_o, m_wdata[w]);
            check("busy_wstrb", mem_wstrb_o, m_wstrb[w]);
            check("busy_grant", grant_o, oh);
            check("busy_res", res_valid_o, 0);
            if (rst_mid && i == 2) begin
                @(negedge clk_i);
                rst_i       = 1'b0;
                req_valid_i = '0;
                mem_ready_i = 1'b0;
                #1;
                check("rst_mvalid", mem_valid_o, 0);
                check("rst_busy", busy_o, 0);
                check("rst_res", res_valid_o, 0);
                check("rst_grant", grant_o, 0);
                m_last = NR - 1;
                return;
            end
        end

        @(negedge clk_i);
        req_valid_i = '0;
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rdata_i = rand128();
        #1;
        check("resp_valid", res_valid_o, oh);
        check("resp_data", res_data_o, exp_data);
        check("resp_err", res_err_o, timed_out);
        check("resp_mvalid", mem_valid_o, 0);
        check("resp_ready", req_ready_o, 0);
        check("resp_grant", grant_o, oh);
    endtask

    task automatic idle_cycle();
        @(negedge clk_i);
        req_valid_i = '0;
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rdata_i = rand128();
        #1;
        check("idle_ready", req_ready_o, 0);
        check("idle_res", res_valid_o, 0);
        check("idle_mvalid", mem_valid_o, 0);
        check("idle_busy2", busy_o, 0);
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_wstrb_i = '0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        m_last      = NR - 1;
        for (int k = 0; k < NR; k++) begin
            m_addr[k] = '0; m_wdata[k] = '0; m_wstrb[k] = '0;
        end

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("rst_ready", req_ready_o, 0);
        check("rst_resv", res_valid_o, 0);
        check("rst_rdata", res_data_o, 0);
        check("rst_rerr", res_err_o, 0);
        check("rst_mv", mem_valid_o, 0);
        check("rst_maddr", mem_addr_o, 0);
        check("rst_mwdata", mem_wdata_o, 0);
        check("rst_mwstrb", mem_wstrb_o, 0);
        check("rst_gnt", grant_o, 0);
        check("rst_bsy", busy_o, 0);
        rst_i = 1'b0;

        // First read from requester 0.
        new_payloads();
        m_addr[0]  = 32'h0000_1000;
        m_wstrb[0] = '0;
        run_txn(3'b001, 3, {4{32'hDEAD_BEEF}}, 1'b0);

        // Full contention rotates 0,1,2,0,1,2.
        for (int n = 0; n < 6; n++) begin
            new_payloads();
            run_txn(3'b111, 2, rand128(), 1'b0);
        end

        // Partial write from requester 1.
        new_payloads();
        m_wstrb[1] = 16'h000F;
        m_wdata[1] = 128'h1122_3344;
        run_txn(3'b010, 3, rand128(), 1'b0);

        // Watchdog expiry, then a normal transaction.
        new_payloads();
        run_txn(3'b100, TO + 5, rand128(), 1'b0);
        new_payloads();
        run_txn(3'b001, 1, rand128(), 1'b0);

        // Completion on the final watchdog cycle beats the timeout.
        new_payloads();
        run_txn(3'b010, TO, rand128(), 1'b0);

        // Reset while busy, then 3-way contention goes to requester 0.
        new_payloads();
        run_txn(3'b110, 5, rand128(), 1'b1);
        new_payloads();
        run_txn(3'b111, 2, rand128(), 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            logic [NR-1:0] mask;
            mask = NR'($urandom_range(1, 7));
            new_payloads();
            run_txn(mask, $urandom_range(1, TO + 2), rand128(), 1'b0);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
